operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/step_board_pkg.sv | 15 +
 rtl/key_debounce.sv | 65 ++++++
 rtl/operand_loader.sv | 106 ++++++++++
 tb/tb_operand_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/step_board_pkg.sv
// step_board_pkg
//   Shared definitions for the step-board operand entry logic:
//   - phase_e : operand-entry FSM encodings (also driven out on the phase port)
//   - DEFAULT_DEBOUNCE_CYCLES : 20 ms of stable input at the 12 MHz board clock
package step_board_pkg;

    typedef enum logic [1:0] {
        PH_ENTER_A = 2'b00,
        PH_ENTER_B = 2'b01,
        PH_DONE    = 2'b10
    } phase_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

endpackage : step_board_pkg

// File: rtl/key_debounce.sv
// key_debounce
//   Conditions one bouncing, active-low push-button: a two-flop synchronizer,
//   a stable-time debouncer and a press-edge detector.
//   Ports:
//     clk    in  board clock
//     rst_n  in  asynchronous active-low reset
//     btn_n  in  raw button level, asynchronous, active-low
//     press  out one-cycle pulse on each debounced 1->0 transition (registered)
module key_debounce
    import step_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sync_d  = {sync_q[0], btn_n};
        level_d = level_q;
        cnt_d   = '0;
        // The count only advances while the synchronized input disagrees with
        // the accepted level; a single agreeing cycle restarts it at zero.
        if (sync_q[1] != level_q) begin
            if (cnt_q >= CNT_MAX) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Only a debounced release->press edge produces a pulse.
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle (released) levels, so reset release with keys up yields no pulse.
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule : key_debounce

// File: rtl/operand_loader.sv
// operand_loader
//   Captures two operands from the switches, one per confirmed key press,
//   for a small adder. A clear press zeroes both operands at any time.
//   Ports:
//     clk       in  12 MHz board clock
//     rst_n     in  asynchronous active-low reset
//     sw        in  operand switches, asynchronous, active-high
//     key_n     in  confirm button, active-low, bouncing
//     clr_n     in  clear button, active-low, bouncing
//     op_a      out captured operand A
//     op_b      out captured operand B
//     op_valid  out both operands captured (phase == DONE)
//     phase     out entry phase: 00 ENTER_A, 01 ENTER_B, 10 DONE
//   All outputs come straight from flops.
module operand_loader
    import step_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int W               = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         key_n,
    input  logic         clr_n,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         op_valid,
    output logic [1:0]   phase
);

    logic         key_pulse, clr_pulse;
    logic [W-1:0] sw_meta_q, sw_sync_q;
    logic [W-1:0] op_a_q, op_a_d;
    logic [W-1:0] op_b_q, op_b_d;
    logic         op_valid_q, op_valid_d;
    phase_e       phase_q, phase_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (key_n),
        .press (key_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (clr_n),
        .press (clr_pulse)
    );

    always_comb begin
        phase_d = phase_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        // Clear wins over a coincident key press, which is simply dropped.
        if (clr_pulse) begin
            phase_d = PH_ENTER_A;
            op_a_d  = '0;
            op_b_d  = '0;
        end else begin
            unique case (phase_q)
                PH_ENTER_A: if (key_pulse) begin
                    op_a_d  = sw_sync_q;
                    phase_d = PH_ENTER_B;
                end
                PH_ENTER_B: if (key_pulse) begin
                    op_b_d  = sw_sync_q;
                    phase_d = PH_DONE;
                end
                PH_DONE: if (key_pulse) begin
                    // Operands are kept for display until overwritten.
                    phase_d = PH_ENTER_A;
                end
                // Illegal code 11 falls back to operand A entry.
                default: phase_d = PH_ENTER_A;
            endcase
        end
        op_valid_d = (phase_d == PH_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '1;
            sw_sync_q  <= '1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            phase_q    <= PH_ENTER_A;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            phase_q    <= phase_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign phase    = phase_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// tb_operand_loader
//   Scoreboard bench: each directed step queues the output state it should
//   produce; a monitor compares every observed output change against the
//   head of the queue and flags any change nobody asked for.
module tb_operand_loader;

    localparam int DB = 4;
    localparam int W  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         key_n;
    logic         clr_n;
    logic [W-1:0] op_a, op_b;
    logic         op_valid;
    logic [1:0]   phase;

    typedef struct {
        string      name;
        logic [6:0] val;   // {op_a, op_b, op_valid, phase}
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev;

    operand_loader #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .key_n    (key_n),
        .clr_n    (clr_n),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] snap();
        return {op_a, op_b, op_valid, phase};
    endfunction

    function automatic logic [6:0] st(input int a, input int b, input int v, input int p);
        return {a[1:0], b[1:0], v[0], p[1:0]};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got a=%0d b=%0d v=%0d ph=%b, want a=%0d b=%0d v=%0d ph=%b",
                     name, got[6:5], got[4:3], got[2], got[1:0],
                     want[6:5], want[4:3], want[2], want[1:0]);
        end
    endtask

    task automatic expect_state(input string name, input logic [6:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: held long enough to debounce both edges.
    task automatic press(input bit key, input bit clr);
        if (key) key_n = 1'b0;
        if (clr) clr_n = 1'b0;
        cycles(12);
        key_n = 1'b1;
        clr_n = 1'b1;
        cycles(12);
    endtask

    // Bounded wait for the monitor to drain all expected changes.
    task automatic wait_sb(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cycles(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d expected changes never seen, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic [6:0] cur;
                cur = snap();
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_change", cur, prev);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check(e.name, cur, e.val);
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        key_n = 1'b1;
        clr_n = 1'b1;
        cycles(3);
        check("reset_state", snap(), st(0, 0, 0, 0));
        rst_n = 1'b1;
        cycles(20);
        check("reset_release_idle", snap(), st(0, 0, 0, 0));
        prev   = snap();
        mon_en = 1'b1;

        // Two clean presses load A=2 then B=3.
        sw = 2'b10;
        expect_state("load_a", st(2, 0, 0, 1));
        press(1, 0);
        wait_sb("load_a");
        sw = 2'b11;
        expect_state("load_b", st(2, 3, 1, 2));
        press(1, 0);
        wait_sb("load_b");
        check("done_state", snap(), st(2, 3, 1, 2));

        // Switch activity alone must not disturb anything.
        for (int i = 0; i < 100; i++) begin
            sw = i[1:0];
            cycles(1);
        end
        check("sw_only_hold", snap(), st(2, 3, 1, 2));

        // Press in DONE: back to ENTER_A, operands retained.
        expect_state("done_to_a", st(2, 3, 0, 0));
        press(1, 0);
        wait_sb("done_to_a");

        // Bounce for 20 cycles then hold low: exactly one advance.
        sw = 2'b01;
        expect_state("bounce_one_advance", st(1, 3, 0, 1));
        for (int i = 0; i < 20; i++) begin
            key_n = (i % 4) >= 2;
            cycles(1);
        end
        key_n = 1'b0;
        cycles(12);
        key_n = 1'b1;
        cycles(12);
        wait_sb("bounce_one_advance");
        cycles(10);
        check("bounce_no_extra", snap(), st(1, 3, 0, 1));

        // Key and clear together in ENTER_B: clear wins.
        expect_state("clr_priority", st(0, 0, 0, 0));
        press(1, 1);
        wait_sb("clr_priority");

        // Reach ENTER_B with op_a=1, then reset mid-debounce.
        sw = 2'b01;
        expect_state("reload_a", st(1, 0, 0, 1));
        press(1, 0);
        wait_sb("reload_a");
        key_n = 1'b0;
        cycles(3);
        expect_state("mid_reset", st(0, 0, 0, 0));
        rst_n = 1'b0;
        key_n = 1'b1;
        cycles(1);
        rst_n = 1'b1;
        wait_sb("mid_reset");
        cycles(30);
        check("post_reset_quiet", snap(), st(0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_operand_loader
